// File: rtl/serial_link_host.sv
// serial_link_host
//
// Host-side master of the Repka-Tang serial link. Serialises a 4-slot
// transmit register file LSB-first into the CPU-side endpoint's input slots,
// and deserialises the endpoint's output slots into 32-bit words. It keeps a
// mirror of the endpoint's slot counter so that every word is tagged with
// its slot.
//
// Ports
//   clk_data      in   link clock
//   sys_reset     in   asynchronous active-high reset, shared with the endpoint
//   run           in   level request for frames (sampled in IDLE and SYNC)
//   wr_en         in   transmit register file write strobe
//   wr_slot[1:0]  in   transmit slot to write
//   wr_data[31:0] in   transmit word
//   dataoutbit    in   serial data from the endpoint (bit i valid in shift cycle i)
//   datainbit     out  serial data to the endpoint (registered)
//   data_sync_en  out  endpoint sync/load strobe, high whenever not shifting (registered)
//   busy          out  high in SHIFT and SYNC
//   tx_slot[1:0]  out  slot targeted by the current or most recent window
//   rx_valid      out  one-cycle pulse, received word on rx_data
//   rx_slot[1:0]  out  endpoint slot the received word came from
//   rx_data[31:0] out  received word, held until the next rx_valid
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no window; data_sync_en=1 keeps the endpoint loading, counter frozen
// SHIFT  | 32 shift cycles, bit_cnt 0..31; one bit out and one bit in per cycle
// SYNC   | one cycle of data_sync_en=1; endpoint stores/reloads, rx_valid=1

module serial_link_host (
    input  logic        clk_data,
    input  logic        sys_reset,
    input  logic        run,
    input  logic        wr_en,
    input  logic [1:0]  wr_slot,
    input  logic [31:0] wr_data,
    input  logic        dataoutbit,
    output logic        datainbit,
    output logic        data_sync_en,
    output logic        busy,
    output logic [1:0]  tx_slot,
    output logic        rx_valid,
    output logic [1:0]  rx_slot,
    output logic [31:0] rx_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SYNC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] txreg [4];
    logic [1:0]  slot;          // mirror of the endpoint's slot counter
    logic [1:0]  load_slot;
    logic [1:0]  cur_rx_slot;
    logic [4:0]  bit_cnt;
    logic [31:0] load_word;
    // Bit 0 of the word goes straight into the datainbit flop at load time,
    // so the shifter only has to hold the remaining 31 bits.
    logic [30:0] tx_shift;
    // The final received bit is taken directly from dataoutbit on the last
    // edge, so only 31 bits need to be accumulated here.
    logic [30:0] rx_shift;
    logic        start_win;
    logic        last_bit;

    // The endpoint advances its counter during the window, so the window
    // being opened targets the slot after the one it is currently showing.
    assign load_slot = slot + 2'd1;
    assign load_word = txreg[load_slot];

    // ------------------------------------------------------------------
    // Transmit register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk_data or posedge sys_reset) begin
        if (sys_reset) begin
            for (int i = 0; i < 4; i++) begin
                txreg[i] <= '0;
            end
        end else if (wr_en) begin
            txreg[wr_slot] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_data or posedge sys_reset) begin
        if (sys_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == 5'd31) begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                state_nxt = run ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        start_win = 1'b0;
        last_bit  = 1'b0;
        case (state)
            ST_IDLE: begin
                start_win = run;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                last_bit = (bit_cnt == 5'd31);
            end
            ST_SYNC: begin
                busy      = 1'b1;
                start_win = run;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shifters, slot mirror, registered link outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_data or posedge sys_reset) begin
        if (sys_reset) begin
            slot         <= 2'd0;
            cur_rx_slot  <= 2'd0;
            bit_cnt      <= 5'd0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            datainbit    <= 1'b0;
            data_sync_en <= 1'b1;
            tx_slot      <= 2'd0;
            rx_valid     <= 1'b0;
            rx_slot      <= 2'd0;
            rx_data      <= '0;
        end else begin
            rx_valid     <= 1'b0;
            // Registered so that the strobe changes in the same cycle the
            // state does; low only for the 32 shift cycles.
            data_sync_en <= (state_nxt != ST_SHIFT);

            if (start_win) begin
                tx_shift    <= load_word[31:1];
                datainbit   <= load_word[0];
                tx_slot     <= load_slot;
                cur_rx_slot <= slot;
                bit_cnt     <= 5'd0;
            end else if (state == ST_SHIFT) begin
                tx_shift  <= {1'b0, tx_shift[30:1]};
                datainbit <= last_bit ? 1'b0 : tx_shift[0];
                rx_shift  <= {dataoutbit, rx_shift[30:1]};
                bit_cnt   <= bit_cnt + 5'd1;
                // The endpoint bumps its counter at the end of the first
                // shift cycle; mirror that exactly.
                if (bit_cnt == 5'd0) begin
                    slot <= slot + 2'd1;
                end
                if (last_bit) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {dataoutbit, rx_shift};
                    rx_slot  <= cur_rx_slot;
                end
            end else begin
                datainbit <= 1'b0;
            end
        end
    end

endmodule
